// File: rtl/operand_collector_pkg.sv
// operand_collector_pkg
// Shared definitions for the operand collector: frame FSM state encoding
// and a ceiling-log2 helper used to size the index and timeout counters.
package operand_collector_pkg;

    // Frame position: collecting operand A, operand B, or the opcode byte.
    typedef enum logic [1:0] {
        ST_A  = 2'd0,
        ST_B  = 2'd1,
        ST_OP = 2'd2
    } state_t;

    // Ceiling log2; clog2(0) = clog2(1) = 0.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/operand_collector_byte_assembler.sv
// byte_assembler
// Builds one NB_DATA-wide little-endian word from a stream of NB_BYTE bytes.
// Ports:
//   clock, reset : rising-edge clock, async active-high reset
//   clear        : return the byte index to 0 (frame discarded)
//   wr, din      : byte strobe and byte; din lands in the slice at the index
//   word         : assembled word (slices written so far; older ones stale)
//   last         : the index points at the most significant slice
module byte_assembler
    import operand_collector_pkg::*;
#(
    parameter int NB_BYTE = 8,
    parameter int NB_DATA = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               wr,
    input  logic [NB_BYTE-1:0] din,
    output logic [NB_DATA-1:0] word,
    output logic               last
);

    localparam int BYTES = NB_DATA / NB_BYTE;
    localparam int IDX_W = (clog2(BYTES) < 1) ? 1 : clog2(BYTES);

    logic [IDX_W-1:0] r_idx;

    assign last = (r_idx == IDX_W'(BYTES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
            word  <= '0;
        end else if (clear) begin
            r_idx <= '0;
        end else if (wr) begin
            word[r_idx*NB_BYTE +: NB_BYTE] <= din;
            r_idx <= last ? '0 : r_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/operand_collector.sv
// operand_collector
// Byte-stream front end for the ALU: collects BYTES bytes of A, BYTES bytes
// of B and one opcode byte, then publishes all three at once with a
// one-cycle o_valid pulse. An inter-byte timeout drops partial frames so a
// lost byte cannot permanently misalign the stream.
// Ports:
//   clock, reset      : rising-edge clock, async active-high reset
//   din, wr           : received byte and its one-cycle strobe
//   o_a, o_b, o_op    : last complete frame (held until the next one)
//   o_valid           : one-cycle pulse, outputs just updated
//   o_busy            : a frame is partially received
//   o_timeout         : one-cycle pulse, partial frame discarded
module operand_collector
    import operand_collector_pkg::*;
#(
    parameter int NB_BYTE = 8,
    parameter int NB_DATA = 16,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 50000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NB_BYTE-1:0] din,
    input  logic               wr,
    output logic [NB_DATA-1:0] o_a,
    output logic [NB_DATA-1:0] o_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_timeout
);

    localparam int CNT_W = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    generate
        if (NB_DATA % NB_BYTE != 0) begin : g_chk_data
            $error("operand_collector: NB_DATA must be a multiple of NB_BYTE");
        end
        if (NB_OP > NB_BYTE) begin : g_chk_op
            $error("operand_collector: NB_OP must not exceed NB_BYTE");
        end
    endgenerate

    state_t             r_state;
    logic               r_mid;      // ST_A with a nonzero byte index
    logic [CNT_W-1:0]   r_cnt;
    logic [NB_DATA-1:0] r_sh_a;
    logic [NB_DATA-1:0] w_word;
    logic [NB_DATA-1:0] w_full;
    logic               w_last;
    logic               w_expire;
    logic               w_asm_wr;

    // The op byte never goes into the shared assembler.
    assign w_asm_wr = wr && (r_state != ST_OP);
    assign o_busy   = (r_state != ST_A) || r_mid;
    // wr on the expiry cycle wins over the timeout.
    assign w_expire = (TIMEOUT != 0) && o_busy && !wr && (r_cnt == CNT_MAX);

    byte_assembler #(
        .NB_BYTE (NB_BYTE),
        .NB_DATA (NB_DATA)
    ) u_asm (
        .clock (clock),
        .reset (reset),
        .clear (w_expire),
        .wr    (w_asm_wr),
        .din   (din),
        .word  (w_word),
        .last  (w_last)
    );

    // The last A byte is being written on the same edge that latches shadow A,
    // so merge din into the top slice rather than waiting a cycle.
    generate
        if (NB_DATA == NB_BYTE) begin : g_full_one
            assign w_full = din;
        end else begin : g_full_multi
            assign w_full = {din, w_word[NB_DATA-NB_BYTE-1:0]};
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_A;
            r_mid     <= 1'b0;
            r_cnt     <= '0;
            r_sh_a    <= '0;
            o_a       <= '0;
            o_b       <= '0;
            o_op      <= '0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;

            if (w_expire) begin
                r_state   <= ST_A;
                r_mid     <= 1'b0;
                o_timeout <= 1'b1;
            end else if (wr) begin
                case (r_state)
                    ST_A: begin
                        if (w_last) begin
                            r_sh_a  <= w_full;
                            r_state <= ST_B;
                            r_mid   <= 1'b0;
                        end else begin
                            r_mid   <= 1'b1;
                        end
                    end
                    ST_B: begin
                        if (w_last) r_state <= ST_OP;
                    end
                    ST_OP: begin
                        o_a     <= r_sh_a;
                        o_b     <= w_word;
                        o_op    <= din[NB_OP-1:0];
                        o_valid <= 1'b1;
                        r_state <= ST_A;
                    end
                    default: r_state <= ST_A;
                endcase
            end

            if (TIMEOUT == 0 || wr || !o_busy || w_expire) r_cnt <= '0;
            else                                         r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_operand_collector.sv
module tb_operand_collector;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [7:0]  din0 = '0, din1 = '0, din2 = '0;
    logic        wr0 = 1'b0, wr1 = 1'b0, wr2 = 1'b0;
    logic [15:0] a0, b0;
    logic [7:0]  a1, b1;
    logic [31:0] a2, b2;
    logic [5:0]  op0, op1, op2;
    logic        v0, v1, v2, bz0, bz1, bz2, t0, t1, t2;

    operand_collector #(.NB_BYTE(8), .NB_DATA(16), .NB_OP(6), .TIMEOUT(16)) dut0 (
        .clock(clock), .reset(reset), .din(din0), .wr(wr0), .o_a(a0), .o_b(b0),
        .o_op(op0), .o_valid(v0), .o_busy(bz0), .o_timeout(t0));
    operand_collector #(.NB_BYTE(8), .NB_DATA(8), .NB_OP(6), .TIMEOUT(16)) dut1 (
        .clock(clock), .reset(reset), .din(din1), .wr(wr1), .o_a(a1), .o_b(b1),
        .o_op(op1), .o_valid(v1), .o_busy(bz1), .o_timeout(t1));
    operand_collector #(.NB_BYTE(8), .NB_DATA(32), .NB_OP(6), .TIMEOUT(0)) dut2 (
        .clock(clock), .reset(reset), .din(din2), .wr(wr2), .o_a(a2), .o_b(b2),
        .o_op(op2), .o_valid(v2), .o_busy(bz2), .o_timeout(t2));

    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [5:0]  vop [3];
    logic        vv [3];
    logic        vt [3];
    assign va[0] = {16'h0, a0};  assign vb[0] = {16'h0, b0};  assign vop[0] = op0;
    assign va[1] = {24'h0, a1};  assign vb[1] = {24'h0, b1};  assign vop[1] = op1;
    assign va[2] = a2;           assign vb[2] = b2;           assign vop[2] = op2;
    assign vv[0] = v0; assign vv[1] = v1; assign vv[2] = v2;
    assign vt[0] = t0; assign vt[1] = t1; assign vt[2] = t2;

    exp_t sbq[$];
    int   exp_to [3] = '{0, 0, 0};
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
        exp_t e;
        e.id = id; e.a = a; e.b = b; e.op = op;
        sbq.push_back(e);
    endtask

    task automatic put(input int id, input logic [7:0] b);
        @(negedge clock);
        wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
        case (id)
            0: begin wr0 = 1'b1; din0 = b; end
            1: begin wr1 = 1'b1; din1 = b; end
            default: begin wr2 = 1'b1; din2 = b; end
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
        end
    endtask

    // Monitor: pops one expected frame per o_valid, accounts for o_timeout.
    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (vv[k] && vt[k]) begin
                checks++; errors++;
                $display("FAIL dut%0d valid_and_timeout: both high together", k);
            end
            if (vv[k]) begin
                checks++;
                if (sbq.size() == 0 || sbq[0].id != k) begin
                    errors++;
                    $display("FAIL dut%0d unexpected_valid: got a=%h b=%h op=%h, expected none", k, va[k], vb[k], vop[k]);
                end else begin
                    if (va[k] !== sbq[0].a || vb[k] !== sbq[0].b || vop[k] !== sbq[0].op) begin
                        errors++;
                        $display("FAIL dut%0d frame: got a=%h b=%h op=%h, expected a=%h b=%h op=%h",
                                 k, va[k], vb[k], vop[k], sbq[0].a, sbq[0].b, sbq[0].op);
                    end
                    void'(sbq.pop_front());
                end
            end
            if (vt[k]) begin
                checks++;
                if (exp_to[k] == 0) begin
                    errors++;
                    $display("FAIL dut%0d unexpected_timeout: got pulse, expected none", k);
                end else begin
                    exp_to[k]--;
                end
            end
        end
    end

    initial begin
        // Reset state
        idle(2);
        chk("rst_a", {16'h0, a0}, 32'h0);
        chk("rst_b", {16'h0, b0}, 32'h0);
        chk("rst_op", {26'h0, op0}, 32'h0);
        chk("rst_flags", {29'h0, v0, bz0, t0}, 32'h0);
        @(negedge clock); reset = 1'b0;
        idle(1);

        // Basic frame with gaps
        put(0, 8'h03); idle(1); put(0, 8'h00); idle(1);
        put(0, 8'h02); idle(1); put(0, 8'h00); idle(1);
        chk("basic_busy_mid", {31'h0, bz0}, 32'h1);
        push(0, 32'h3, 32'h2, 6'h20);
        put(0, 8'h20); idle(1);
        chk("basic_valid", {31'h0, v0}, 32'h1);
        chk("basic_busy_after", {31'h0, bz0}, 32'h0);
        idle(1);
        chk("basic_valid_1cyc", {31'h0, v0}, 32'h0);
        chk("basic_hold_a", {16'h0, a0}, 32'h3);

        // Back-to-back frames at full rate
        put(0, 8'h34); put(0, 8'h12); put(0, 8'h78); put(0, 8'h56);
        push(0, 32'h1234, 32'h5678, 6'h24);
        put(0, 8'h24);
        put(0, 8'hFF); put(0, 8'hFF); put(0, 8'h00); put(0, 8'h00);
        push(0, 32'hFFFF, 32'h0, 6'h3F);
        put(0, 8'h3F);
        idle(3);

        // Timeout discards a partial frame
        put(0, 8'h03); put(0, 8'h00); put(0, 8'h02);
        exp_to[0]++;
        idle(16);
        chk("to_not_yet", {31'h0, t0}, 32'h0);
        chk("to_busy_before", {31'h0, bz0}, 32'h1);
        idle(1);
        chk("to_pulse", {31'h0, t0}, 32'h1);
        chk("to_busy_after", {31'h0, bz0}, 32'h0);
        chk("to_hold_a", {16'h0, a0}, 32'hFFFF);
        chk("to_hold_b", {16'h0, b0}, 32'h0);
        chk("to_hold_op", {26'h0, op0}, 32'h3F);
        idle(1);
        put(0, 8'h05); put(0, 8'h00); put(0, 8'h06); put(0, 8'h00);
        push(0, 32'h5, 32'h6, 6'h22);
        put(0, 8'h22);
        idle(2);

        // wr on the expiry cycle wins
        put(0, 8'h03); put(0, 8'h00); put(0, 8'h02);
        idle(15);
        chk("race_busy", {31'h0, bz0}, 32'h1);
        put(0, 8'h00);
        push(0, 32'h3, 32'h2, 6'h2A);
        put(0, 8'h2A);
        idle(2);
        chk("race_no_timeout", {31'h0, t0}, 32'h0);

        // Asynchronous reset mid-frame
        put(0, 8'h05); put(0, 8'h00); put(0, 8'h07);
        @(posedge clock); #2 reset = 1'b1;
        #1;
        chk("arst_a", {16'h0, a0}, 32'h0);
        chk("arst_b", {16'h0, b0}, 32'h0);
        chk("arst_op", {26'h0, op0}, 32'h0);
        chk("arst_busy", {31'h0, bz0}, 32'h0);
        @(negedge clock); reset = 1'b0; wr0 = 1'b0;
        idle(1);
        put(0, 8'h11); put(0, 8'h00); put(0, 8'h22); put(0, 8'h00);
        push(0, 32'h11, 32'h22, 6'h33);
        put(0, 8'h33);
        idle(2);

        // NB_DATA = 8
        put(1, 8'h03); put(1, 8'h02);
        push(1, 32'h3, 32'h2, 6'h20);
        put(1, 8'h20);
        idle(2);
        chk("w8_a", {24'h0, a1}, 32'h3);

        // NB_DATA = 32, TIMEOUT = 0: long idle mid-frame is harmless
        put(2, 8'h78); put(2, 8'h56); put(2, 8'h34); put(2, 8'h12);
        put(2, 8'hEF); put(2, 8'hBE);
        idle(100);
        chk("w32_busy_idle", {31'h0, bz2}, 32'h1);
        chk("w32_no_timeout", {31'h0, t2}, 32'h0);
        put(2, 8'hAD); put(2, 8'hDE);
        push(2, 32'h12345678, 32'hDEADBEEF, 6'h15);
        put(2, 8'h15);
        idle(2);
        chk("w32_a", a2, 32'h12345678);
        chk("w32_b", b2, 32'hDEADBEEF);

        idle(2);
        chk("sb_drained", sbq.size(), 32'h0);
        chk("to_drained", exp_to[0] + exp_to[1] + exp_to[2], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_collector.md
# operand_collector

Parametrised byte-stream front end for the ALU datapath. Receives bytes from the UART receiver on a one-cycle write strobe and assembles them into two operands (A, B) and an opcode of configurable width. Publishes all three atomically with a one-cycle valid pulse. Adds an inter-byte timeout that discards partial frames, so a lost byte can never permanently misalign A/B/Op.

## Interface
- NB_BYTE, 8, width of one received byte
- NB_DATA, 16, operand width; must be an integer multiple of NB_BYTE (8, 16, 32 legal)
- NB_OP, 6, opcode width; must be ≤ NB_BYTE, taken from the low bits of the op byte
- TIMEOUT, 50000, idle cycles inside a frame before it is discarded; 0 disables the timeout
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- din  in  NB_BYTE  received byte, sampled when wr=1
- wr  in  1  byte strobe; each cycle high = one byte accepted
- o_a  out  NB_DATA  operand A of last complete frame
- o_b  out  NB_DATA  operand B of last complete frame
- o_op  out  NB_OP  opcode of last complete frame
- o_valid  out  1  one-cycle pulse: o_a/o_b/o_op just updated
- o_busy  out  1  high while a frame is partially received
- o_timeout  out  1  one-cycle pulse: partial frame discarded

## Operation
- Frame format: BYTES = NB_DATA/NB_BYTE bytes of A, then BYTES bytes of B, then 1 op byte. Multi-byte operands are little-endian: the first byte lands in bits [NB_BYTE-1:0].
- FSM states: ST_A, ST_B, ST_OP. Reset state is ST_A with byte index 0.
- ST_A / ST_B: on wr, write din into the shadow register slice selected by the byte index, then increment the index. When the index reaches BYTES-1 and wr occurs, clear the index and advance (A→B, B→OP).
- ST_OP: on wr, load o_a, o_b and o_op (din[NB_OP-1:0]) from the shadow registers and din in the same edge. Pulse o_valid, then return to ST_A.
- Outputs hold their last complete frame until the next complete frame. Partial or discarded frames never alter o_a, o_b or o_op.
- o_busy = NOT (state==ST_A AND index==0). It is combinational from registered state.
- Timeout counter: cleared on every wr and whenever o_busy=0. Increments each idle cycle while o_busy=1. On reaching TIMEOUT-1 without wr: return to ST_A, clear index, pulse o_timeout. Shadow registers may keep stale contents.
- Simultaneous wr and timeout expiry: wr wins. The byte is accepted, the counter is cleared, and no o_timeout pulse is generated.
- TIMEOUT=0: the counter is held at 0 and o_timeout stays 0.
- Reset asserted mid-frame: the frame is lost; everything returns to reset values immediately (asynchronous).

## Timing
- Reset values: o_a=0, o_b=0, o_op=0, o_valid=0, o_timeout=0, o_busy=0, state ST_A, index 0, counter 0.
- Latency: o_valid is high, and the new outputs are visible, in the cycle after the clock edge that samples the op-byte wr. That is one cycle of latency.
- o_valid and o_timeout are exactly one cycle wide and never high together.
- Back-to-back wr on consecutive cycles is legal at full rate. A new frame may start in the cycle o_valid is high.
- A frame spans a minimum of 2·BYTES+1 cycles.
- Counter width is clog2(TIMEOUT+1). Index width is clog2(BYTES), minimum 1.

## Structure
- Package operand_collector_pkg holds the state encoding localparams ST_A/ST_B/ST_OP (2-bit) and a clog2 helper function.
- Sub-module byte_assembler assembles one NB_DATA-wide word. It contains the byte index counter and a slice-write register, and its ports are clock, reset, clear, wr, din, word, last. It is instantiated once and shared between A and B: the FSM latches its word into shadow A at the A→B transition.
- The timeout counter and FSM live in the top module.
- Parameter checks: elaboration-time $error if NB_DATA % NB_BYTE ≠ 0 or NB_OP > NB_BYTE.

## Test plan
All scenarios use NB_DATA=16, NB_OP=6, TIMEOUT=16 unless noted.
- Basic frame: wr bytes 03,00,02,00,20 on separate cycles → one cycle after the 5th wr: o_a=0x0003, o_b=0x0002, o_op=0x20, o_valid=1 for exactly 1 cycle; o_busy=0 afterwards.
- Back-to-back frames: wr high 10 consecutive cycles with bytes 34,12,78,56,24,FF,FF,00,00,3F → first o_valid with o_a=0x1234, o_b=0x5678, o_op=0x24; second o_valid 5 cycles later with o_a=0xFFFF, o_b=0x0000, o_op=0x3F.
- Timeout: send 03,00,02, then idle 16 cycles → o_timeout pulses once, o_busy drops, o_a/o_b/o_op unchanged. A following full frame 05,00,06,00,22 decodes as o_a=5, o_b=6, o_op=0x22.
- Timeout race: wr on exactly the expiry cycle → no o_timeout, byte accepted, frame completes correctly.
- Reset mid-frame: assert reset after 3 bytes → all outputs 0 immediately. The next full frame decodes correctly.
- Width sweep: NB_DATA=8 with bytes 03,02,20 → o_a=3, o_b=2, o_op=0x20. NB_DATA=32 with 4+4+1 bytes → correct little-endian assembly. With TIMEOUT=0, idle 100 cycles mid-frame → no timeout, frame resumes.
